// File: rtl/alu_ctrl_pkg.sv
// Shared constants and ALU decode helper for alu_ctrl_dmem.
// Optional flag logic is enabled with macro ALU_FLAGS_EN.
package alu_ctrl_pkg;

  localparam int DMEM_WORDS_DEF = 256;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  // SUB only exists in R-type; funct7[5] selects SRA for both forms.
  function automatic alu_op_e alu_dec(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_r
  );
    case (f3)
      3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// 32-bit ALU with Zero flag; Carry/Overflow only with ALU_FLAGS_EN.
module alu_core
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y,
  output logic        zero,
  output logic        carry,
  output logic        overflow
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_SLL:   y = a << b[4:0];
      ALU_SRL:   y = a >> b[4:0];
      ALU_SRA:   y = $signed(a) >>> b[4:0];
      ALU_SLT:   y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  y = {31'd0, a < b};
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

  assign zero = (y == 32'd0);

`ifdef ALU_FLAGS_EN
  logic [32:0] sum_w;
  logic [32:0] dif_w;

  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, a} - {1'b0, b};

  // dif_w[32] is the borrow, so carry is its inverse.
  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        carry    = sum_w[32];
        overflow = (a[31] == b[31]) &&
                   (sum_w[31] != a[31]);
      end
      ALU_SUB: begin
        carry    = ~dif_w[32];
        overflow = (a[31] != b[31]) &&
                   (dif_w[31] != a[31]);
      end
      default: ;
    endcase
  end
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_dmem.sv
// Decoder, operand mux, ALU and word-addressed data memory.
// ALU_FLAGS_EN enables Carry/Overflow in alu_core.
module alu_ctrl_dmem
  import alu_ctrl_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        brEq,
  input  logic        brLt,
  output logic        branch,
  output logic        pc_sel,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUsrc,
  output logic        RegWrite,
  output logic        brUn,
  output logic [3:0]  ALUop,
  output logic [2:0]  immsel,
  output logic [31:0] alu_result,
  output logic        Zero,
  output logic        Carry,
  output logic        Overflow,
  output logic [31:0] mem_data,
  output logic [31:0] wb_data
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  alu_op_e     alu_op;
  logic [31:0] opb;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        wr_en;
  logic [31:0] mem_q [DMEM_WORDS];
  logic        unused_bits;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign alt    = instruction[30];
  assign unused_bits = ^{instruction[31],
                         instruction[29:15],
                         instruction[11:7]};

  always_comb begin
    branch   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUsrc   = 1'b0;
    RegWrite = 1'b0;
    brUn     = 1'b0;
    alu_op   = ALU_ADD;
    immsel   = IMM_I;
    unique case (1'b1)
      (opcode == OP_R): begin
        RegWrite = 1'b1;
        alu_op   = alu_dec(funct3, alt, 1'b1);
      end
      (opcode == OP_I): begin
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
        alu_op   = alu_dec(funct3, alt, 1'b0);
      end
      (opcode == OP_LW): begin
        MemRead  = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
      end
      (opcode == OP_SW): begin
        MemWrite = 1'b1;
        ALUsrc   = 1'b1;
        immsel   = IMM_S;
      end
      (opcode == OP_BR): begin
        branch = 1'b1;
        immsel = IMM_B;
        alu_op = ALU_SUB;
        brUn   = (funct3 == 3'b110) ||
                 (funct3 == 3'b111);
      end
      (opcode == OP_LUI): begin
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
        immsel   = IMM_U;
        alu_op   = ALU_PASSB;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_sel = 1'b0;
    if (branch) begin
      case (funct3)
        3'b000:         pc_sel = brEq;
        3'b001:         pc_sel = ~brEq;
        3'b100, 3'b110: pc_sel = brLt;
        3'b101, 3'b111: pc_sel = ~brLt;
        default:        pc_sel = 1'b0;
      endcase
    end
  end

  assign ALUop = alu_op;
  assign opb   = ALUsrc ? imm : rs2_data;

  alu_core u_alu (
    .a        (rs1_data),
    .b        (opb),
    .op       (alu_op),
    .y        (alu_result),
    .zero     (Zero),
    .carry    (Carry),
    .overflow (Overflow)
  );

  assign idx      = alu_result[AW+1:2];
  assign in_range = (alu_result >> (AW + 2)) == 32'd0;
  assign wr_en    = MemWrite && in_range;

  always_comb begin
    mem_data = '0;
    if (MemRead && in_range)
      mem_data = mem_q[idx];
  end

  assign wb_data = MemtoReg ? mem_data : alu_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_WORDS; i++)
        mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= rs2_data;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Scoreboard bench for alu_ctrl_dmem; flag expectations follow ALU_FLAGS_EN.
module tb_alu_ctrl_dmem;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111;

`ifdef ALU_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic        brEq = 1'b0;
  logic        brLt = 1'b0;
  logic        branch, pc_sel, MemRead, MemWrite;
  logic        MemtoReg, ALUsrc, RegWrite, brUn;
  logic [3:0]  ALUop;
  logic [2:0]  immsel;
  logic [31:0] alu_result, mem_data, wb_data;
  logic        Zero, Carry, Overflow;
  logic [7:0]  ctl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] mem;
    logic [31:0] wb;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  alu_ctrl_dmem #(.DMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .brEq(brEq), .brLt(brLt),
    .branch(branch), .pc_sel(pc_sel),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUsrc(ALUsrc),
    .RegWrite(RegWrite), .brUn(brUn),
    .ALUop(ALUop), .immsel(immsel),
    .alu_result(alu_result), .Zero(Zero),
    .Carry(Carry), .Overflow(Overflow),
    .mem_data(mem_data), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  assign ctl = {branch, pc_sel, MemRead, MemWrite,
                MemtoReg, ALUsrc, RegWrite, brUn};

  function automatic logic [31:0] mk(
    input logic [6:0] f7, input logic [2:0] f3,
    input logic [6:0] op);
    return {f7, 10'd0, f3, 5'd0, op};
  endfunction

  function automatic logic [31:0] ref_r(
    input logic [2:0] f3, input logic alt,
    input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] im);
    @(negedge clk);
    instruction = ins;
    rs1_data = a;
    rs2_data = b;
    imm = im;
  endtask

  task automatic test_reset();
    drive(mk(0, 3'd2, SW), 32'h10, 32'h1111, 32'h4);
    @(posedge clk);
    drive(mk(0, 3'd2, LW), 32'h10, 0, 32'h4);
    sb.push_back('{32'h14, 0, 0, 1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (mem_data !== e.mem) begin
      errors++;
      $display("FAIL reset_mem got %h want %h", mem_data, e.mem);
    end
    checks++;
    if (ctl !== 8'b0010_1110) begin
      errors++;
      $display("FAIL lw_ctl got %b want 00101110", ctl);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_add_ovf();
    drive(mk(0, 3'd0, R), 32'h7FFFFFFF, 32'h1, 32'h5);
    sb.push_back('{32'h80000000, 0, 32'h80000000,
                   1'b0, 1'b0, FL});
    #1 e = sb.pop_front();
    checks++;
    if (wb_data !== e.wb || alu_result !== e.res) begin
      errors++;
      $display("FAIL add_res got %h want %h", alu_result, e.res);
    end
    checks++;
    if ({Zero, Carry, Overflow} !== {e.z, e.c, e.v}) begin
      errors++;
      $display("FAIL add_flags got %b want %b",
               {Zero, Carry, Overflow}, {e.z, e.c, e.v});
    end
    checks++;
    if (ctl !== 8'b0000_0010 || ALUop !== 4'd0) begin
      errors++;
      $display("FAIL add_ctl got %b/%h want 00000010/0", ctl, ALUop);
    end
  endtask

  task automatic test_sub_zero();
    drive(mk(7'h20, 3'd0, R), 32'd5, 32'd5, 32'd9);
    sb.push_back('{32'h0, 0, 32'h0, 1'b1, FL, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (alu_result !== e.res || ALUop !== 4'd1) begin
      errors++;
      $display("FAIL sub_res got %h/%h want %h/1",
               alu_result, ALUop, e.res);
    end
    checks++;
    if ({Zero, Carry, Overflow} !== {e.z, e.c, e.v}) begin
      errors++;
      $display("FAIL sub_flags got %b want %b",
               {Zero, Carry, Overflow}, {e.z, e.c, e.v});
    end
  endtask

  task automatic test_store_load();
    drive(mk(0, 3'd2, SW), 32'h10, 32'hDEADBEEF, 32'h4);
    sb.push_back('{32'h14, 0, 32'h14, 1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (alu_result !== e.res || mem_data !== e.mem) begin
      errors++;
      $display("FAIL sw_addr got %h/%h want %h/%h",
               alu_result, mem_data, e.res, e.mem);
    end
    checks++;
    if (ctl !== 8'b0001_0100 || immsel !== 3'd1 ||
        ALUop !== 4'd0) begin
      errors++;
      $display("FAIL sw_ctl got %b/%h want 00010100/1", ctl, immsel);
    end
    @(posedge clk);
    drive(mk(0, 3'd2, LW), 32'h10, 0, 32'h4);
    sb.push_back('{32'h14, 32'hDEADBEEF, 32'hDEADBEEF,
                   1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (mem_data !== e.mem || wb_data !== e.wb) begin
      errors++;
      $display("FAIL lw_data got %h/%h want %h",
               mem_data, wb_data, e.wb);
    end
    drive(mk(0, 3'd2, LW), 32'h13, 0, 32'h4);
    sb.push_back('{32'h17, 32'hDEADBEEF, 32'hDEADBEEF,
                   1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (wb_data !== e.wb) begin
      errors++;
      $display("FAIL lw_lowbits got %h want %h", wb_data, e.wb);
    end
  endtask

  task automatic test_out_of_range();
    drive(mk(0, 3'd2, SW), 32'h400, 32'h12345678, 0);
    @(posedge clk);
    drive(mk(0, 3'd2, LW), 32'h0, 0, 0);
    sb.push_back('{32'h0, 0, 0, 1'b1, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (mem_data !== e.mem) begin
      errors++;
      $display("FAIL oor_alias got %h want %h", mem_data, e.mem);
    end
    drive(mk(0, 3'd2, LW), 32'h400, 0, 0);
    sb.push_back('{32'h400, 0, 0, 1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (mem_data !== e.mem || wb_data !== e.wb) begin
      errors++;
      $display("FAIL oor_read got %h want %h", mem_data, e.mem);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [4] = '{3'b001, 3'b000, 3'b110, 3'b101};
    logic       eqs [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       lts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       tkn [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       uns [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(mk(0, f3s[k], BR), 1, 2, 0);
      brEq = eqs[k];
      brLt = lts[k];
      #1;
      checks++;
      if ({branch, pc_sel, RegWrite, brUn, immsel} !==
          {1'b1, tkn[k], 1'b0, uns[k], 3'd2}) begin
        errors++;
        $display("FAIL br%0d got %b%b%b%b/%h want 1%b0%b/2", k,
                 branch, pc_sel, RegWrite, brUn, immsel,
                 tkn[k], uns[k]);
      end
    end
    brEq = 1'b0;
    brLt = 1'b0;
  endtask

  task automatic test_reset_clears();
    drive(mk(0, 3'd2, SW), 32'h20, 32'hCAFEF00D, 0);
    @(posedge clk);
    drive(mk(0, 3'd2, LW), 32'h20, 0, 0);
    #1 reset = 1'b0;
    sb.push_back('{32'h20, 0, 0, 1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (mem_data !== e.mem) begin
      errors++;
      $display("FAIL rst_clear got %h want %h", mem_data, e.mem);
    end
    @(negedge clk) reset = 1'b1;
    #1;
    checks++;
    if (mem_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_after got %h want 0", mem_data);
    end
  endtask

  task automatic test_misc();
    drive(32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3);
    #1;
    checks++;
    if (ctl !== 8'h00 || ALUop !== 4'd0 || immsel !== 3'd0) begin
      errors++;
      $display("FAIL illegal got %b/%h/%h want 0", ctl, ALUop, immsel);
    end
    drive(mk(7'h20, 3'd5, I), 32'h80000000, 32'h3, 32'h404);
    sb.push_back('{32'hF8000000, 0, 32'hF8000000,
                   1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (wb_data !== e.wb || ctl !== 8'b0000_0110) begin
      errors++;
      $display("FAIL srai got %h/%b want %h", wb_data, ctl, e.wb);
    end
    drive(mk(0, 3'd0, LUI), 32'h99, 32'h7, 32'h12345000);
    sb.push_back('{32'h12345000, 0, 32'h12345000,
                   1'b0, 1'b0, 1'b0});
    #1 e = sb.pop_front();
    checks++;
    if (alu_result !== e.res || immsel !== 3'd3 ||
        ALUop !== 4'd10 || ctl !== 8'b0000_0110) begin
      errors++;
      $display("FAIL lui got %h/%h want %h", alu_result, immsel, e.res);
    end
  endtask

  task automatic test_alu_sweep();
    logic [31:0] a, b;
    logic [2:0]  f3;
    logic        alt;
    for (int k = 0; k < 32; k++) begin
      a = $urandom;
      b = (k < 8) ? a : $urandom;
      f3 = 3'(k);
      alt = k[3];
      drive(mk({1'b0, alt, 5'd0}, f3, R), a, b, ~b);
      sb.push_back('{ref_r(f3, alt, a, b), 0, 0, 1'b0, 1'b0, 1'b0});
      #1 e = sb.pop_front();
      checks++;
      if (alu_result !== e.res || Zero !== (e.res == 0)) begin
        errors++;
        $display("FAIL sweep%0d got %h want %h", k, alu_result, e.res);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_zero();
    test_store_load();
    test_out_of_range();
    test_branch();
    test_reset_clears();
    test_misc();
    test_alu_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
